usb_rx_sequencer: RTL and testbench

Receive-side packet controller for the USB full-speed core. It sits after NRZI decode and the bit-level helpers: bit clock recovery, bit de-stuffing, sync detection and CRC5/CRC16 checkers. It sequences those helpers through SYNC → PID → payload → EOP. It gates and re-arms the CRC checkers, assembles bytes LSB-first, and reports per-packet PID, payload bytes and a pass/fail verdict to the protocol engine.

---
 rtl/usb_rx_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_usb_rx_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_sequencer
// Brief    : USB full-speed receive packet sequencer. Walks SYNC -> PID ->
//            body -> EOP, gates/re-arms the CRC5/CRC16 checkers, assembles
//            bytes LSB-first and reports PID, bytes and a per-packet verdict.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_sequencer #(
    parameter int MAX_BYTES = 1026
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_stb,
    input  logic       bit_valid,
    input  logic       d,
    input  logic       sync,
    input  logic       se0,
    input  logic       usb_rst,
    input  logic       crc5_valid,
    input  logic       crc16_valid,
    output logic       crc_rst_n,
    output logic       crc_clken,
    output logic       rx_active,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic [7:0] rx_data,
    output logic       data_stb,
    output logic       pkt_end,
    output logic       pkt_ok,
    output logic       pkt_err
);

    localparam int c_CNT_W = $clog2(MAX_BYTES + 1);

    // Packet kind is the low two PID bits, so these match the PID encoding.
    localparam logic [1:0] c_KIND_SPECIAL   = 2'b00;
    localparam logic [1:0] c_KIND_TOKEN     = 2'b01;
    localparam logic [1:0] c_KIND_HANDSHAKE = 2'b10;
    localparam logic [1:0] c_KIND_DATA      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PID      = 3'd1,
        S_BODY     = 3'd2,
        S_ERR_WAIT = 3'd3,
        S_WAIT_J   = 3'd4
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [2:0]         r_bit_cnt,    w_bit_cnt_nxt;
    logic [c_CNT_W-1:0] r_byte_cnt,   w_byte_cnt_nxt;
    logic [7:0]         r_sr,         w_sr_nxt;
    logic [1:0]         r_kind,       w_kind_nxt;
    logic               r_crc_ok,     w_crc_ok_nxt;
    logic               r_crc_rst_n,  w_crc_rst_n_nxt;
    logic [3:0]         r_rx_pid,     w_rx_pid_nxt;
    logic               r_pid_valid,  w_pid_valid_nxt;
    logic [7:0]         r_rx_data,    w_rx_data_nxt;
    logic               r_data_stb,   w_data_stb_nxt;
    logic               r_pkt_end,    w_pkt_end_nxt;
    logic               r_pkt_ok,     w_pkt_ok_nxt;
    logic               r_pkt_err,    w_pkt_err_nxt;

    logic               w_data_bit;
    logic               w_eop;
    logic [7:0]         w_shifted;
    logic [c_CNT_W-1:0] w_max_bytes;
    logic               w_len_ok;
    logic               w_crc_sel;
    logic               w_pid_good;

    assign w_data_bit = bit_stb && bit_valid;
    assign w_eop      = bit_stb && se0;
    assign w_shifted  = {d, r_sr[7:1]};
    assign w_pid_good = (w_shifted[7:4] == ~w_shifted[3:0]);
    assign w_crc_sel  = (r_kind == c_KIND_TOKEN) ? crc5_valid : crc16_valid;

    // Per-kind byte limits and end-of-packet length acceptance.
    always_comb begin
        w_max_bytes = '0;
        w_len_ok    = 1'b0;
        case (r_kind)
            c_KIND_TOKEN: begin
                w_max_bytes = c_CNT_W'(2);
                w_len_ok    = (r_byte_cnt == c_CNT_W'(2));
            end
            c_KIND_DATA: begin
                w_max_bytes = c_CNT_W'(MAX_BYTES);
                w_len_ok    = (r_byte_cnt >= c_CNT_W'(2));
            end
            c_KIND_HANDSHAKE: begin
                w_max_bytes = '0;
                w_len_ok    = (r_byte_cnt == '0);
            end
            default: begin
                w_max_bytes = '0;
                w_len_ok    = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; bus reset overrides everything but
    // the held verdict.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_sr_nxt        = r_sr;
        w_kind_nxt      = r_kind;
        w_crc_ok_nxt    = r_crc_ok;
        w_rx_pid_nxt    = r_rx_pid;
        w_pid_valid_nxt = 1'b0;
        w_rx_data_nxt   = r_rx_data;
        w_data_stb_nxt  = 1'b0;
        w_pkt_end_nxt   = 1'b0;
        w_pkt_ok_nxt    = r_pkt_ok;
        w_pkt_err_nxt   = r_pkt_err;

        case (r_state)
            S_IDLE: begin
                if (bit_stb && sync && !se0) begin
                    w_state_nxt    = S_PID;
                    w_bit_cnt_nxt  = '0;
                    w_byte_cnt_nxt = '0;
                end
            end
            S_PID: begin
                if (w_eop) begin
                    w_pkt_end_nxt = 1'b1;
                    w_pkt_ok_nxt  = 1'b0;
                    w_pkt_err_nxt = 1'b1;
                    w_state_nxt   = S_WAIT_J;
                end else if (w_data_bit) begin
                    w_sr_nxt      = w_shifted;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_pid_good) begin
                            w_pid_valid_nxt = 1'b1;
                            w_rx_pid_nxt    = w_shifted[3:0];
                            w_kind_nxt      = w_shifted[1:0];
                            w_byte_cnt_nxt  = '0;
                            w_state_nxt     = (w_shifted[1:0] == c_KIND_SPECIAL)
                                              ? S_ERR_WAIT : S_BODY;
                        end else begin
                            w_state_nxt = S_ERR_WAIT;
                        end
                    end
                end
            end
            S_BODY: begin
                if (w_eop) begin
                    w_pkt_end_nxt = 1'b1;
                    w_pkt_ok_nxt  = (r_bit_cnt == 3'd0) && w_len_ok &&
                                    ((r_kind == c_KIND_HANDSHAKE) || r_crc_ok);
                    w_pkt_err_nxt = !w_pkt_ok_nxt;
                    w_state_nxt   = S_WAIT_J;
                end else if (w_data_bit) begin
                    w_sr_nxt      = w_shifted;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    w_crc_ok_nxt  = w_crc_sel;
                    if (r_bit_cnt == 3'd7) begin
                        // A byte beyond the kind's limit aborts the packet,
                        // which also keeps the byte counter from wrapping.
                        if (r_byte_cnt >= w_max_bytes) begin
                            w_state_nxt = S_ERR_WAIT;
                        end else begin
                            w_data_stb_nxt = 1'b1;
                            w_rx_data_nxt  = w_shifted;
                            w_byte_cnt_nxt = r_byte_cnt + c_CNT_W'(1);
                        end
                    end
                end
            end
            S_ERR_WAIT: begin
                if (w_eop) begin
                    w_pkt_end_nxt = 1'b1;
                    w_pkt_ok_nxt  = 1'b0;
                    w_pkt_err_nxt = 1'b1;
                    w_state_nxt   = S_WAIT_J;
                end
            end
            S_WAIT_J: begin
                if (bit_stb && !se0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (usb_rst) begin
            w_state_nxt     = S_IDLE;
            w_pid_valid_nxt = 1'b0;
            w_data_stb_nxt  = 1'b0;
            w_pkt_end_nxt   = 1'b0;
            w_pkt_ok_nxt    = r_pkt_ok;
            w_pkt_err_nxt   = r_pkt_err;
        end

        // Checkers run only while a packet is being received; held in preset
        // in IDLE and WAIT_J so they are clean before the next PID.
        w_crc_rst_n_nxt = (w_state_nxt == S_PID) || (w_state_nxt == S_BODY) ||
                          (w_state_nxt == S_ERR_WAIT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_sr        <= '0;
            r_kind      <= c_KIND_SPECIAL;
            r_crc_ok    <= 1'b0;
            r_crc_rst_n <= 1'b0;
            r_rx_pid    <= '0;
            r_pid_valid <= 1'b0;
            r_rx_data   <= '0;
            r_data_stb  <= 1'b0;
            r_pkt_end   <= 1'b0;
            r_pkt_ok    <= 1'b0;
            r_pkt_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_sr        <= w_sr_nxt;
            r_kind      <= w_kind_nxt;
            r_crc_ok    <= w_crc_ok_nxt;
            r_crc_rst_n <= w_crc_rst_n_nxt;
            r_rx_pid    <= w_rx_pid_nxt;
            r_pid_valid <= w_pid_valid_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_data_stb  <= w_data_stb_nxt;
            r_pkt_end   <= w_pkt_end_nxt;
            r_pkt_ok    <= w_pkt_ok_nxt;
            r_pkt_err   <= w_pkt_err_nxt;
        end
    end

    assign crc_rst_n = r_crc_rst_n;
    assign crc_clken = bit_stb && bit_valid && (r_state == S_BODY);
    assign rx_active = (r_state != S_IDLE);
    assign rx_pid    = r_rx_pid;
    assign pid_valid = r_pid_valid;
    assign rx_data   = r_rx_data;
    assign data_stb  = r_data_stb;
    assign pkt_end   = r_pkt_end;
    assign pkt_ok    = r_pkt_ok;
    assign pkt_err   = r_pkt_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_sequencer
// Brief    : Scoreboard bench for usb_rx_sequencer with behavioural CRC5 and
//            CRC16 residual checkers on the CRC control outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_stb = 1'b0;
    logic       bit_valid = 1'b0;
    logic       d = 1'b0;
    logic       sync = 1'b0;
    logic       se0 = 1'b0;
    logic       usb_rst = 1'b0;
    logic       crc5_valid;
    logic       crc16_valid;
    logic       crc_rst_n;
    logic       crc_clken;
    logic       rx_active;
    logic [3:0] rx_pid;
    logic       pid_valid;
    logic [7:0] rx_data;
    logic       data_stb;
    logic       pkt_end;
    logic       pkt_ok;
    logic       pkt_err;

    usb_rx_sequencer #(.MAX_BYTES(1026)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_stb    (bit_stb),
        .bit_valid  (bit_valid),
        .d          (d),
        .sync       (sync),
        .se0        (se0),
        .usb_rst    (usb_rst),
        .crc5_valid (crc5_valid),
        .crc16_valid(crc16_valid),
        .crc_rst_n  (crc_rst_n),
        .crc_clken  (crc_clken),
        .rx_active  (rx_active),
        .rx_pid     (rx_pid),
        .pid_valid  (pid_valid),
        .rx_data    (rx_data),
        .data_stb   (data_stb),
        .pkt_end    (pkt_end),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err)
    );

    always #5 clk = ~clk;

    // Serial CRC checkers; the valid outputs look ahead to include the bit
    // being clocked so the sequencer samples the post-bit residual.
    logic [4:0]  m_c5  = 5'h1F;
    logic [15:0] m_c16 = 16'hFFFF;

    function automatic logic [4:0] c5_next(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? 5'h05 : 5'h00);
    endfunction

    function automatic logic [15:0] c16_next(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    assign crc5_valid  = (c5_next(m_c5, d) == 5'h0C);
    assign crc16_valid = (c16_next(m_c16, d) == 16'h800D);

    always @(posedge clk) begin
        if (!crc_rst_n) begin
            m_c5  <= 5'h1F;
            m_c16 <= 16'hFFFF;
        end else if (crc_clken) begin
            m_c5  <= c5_next(m_c5, d);
            m_c16 <= c16_next(m_c16, d);
        end
    end

    // Scoreboard
    localparam logic [1:0] E_PID  = 2'd0;
    localparam logic [1:0] E_DATA = 2'd1;
    localparam logic [1:0] E_END  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input logic [1:0] k, input logic [7:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic check_evt(input logic [1:0] k, input logic [7:0] v);
        exp_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event kind=%0d val=%02h, nothing expected (t=%0t)", k, v, $time);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.val != v) begin
                n_bad++;
                $display("FAIL event_order got kind=%0d val=%02h, expected kind=%0d val=%02h (t=%0t)",
                         k, v, e.kind, e.val, $time);
            end
        end
    endtask

    // Monitor: compares every output pulse against the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pid_valid) check_evt(E_PID, {4'h0, rx_pid});
            if (data_stb)  check_evt(E_DATA, rx_data);
            if (pkt_end) begin
                check_evt(E_END, {6'd0, pkt_ok, pkt_err});
                n_cmp++;
                if (pkt_ok && pkt_err) begin
                    n_bad++;
                    $display("FAIL verdict_exclusive got ok=1 err=1, expected at most one set");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus: one bit strobe every 4 clocks.
    int   ones = 0;
    logic stuff_en = 1'b0;

    task automatic strobe(input logic b, input logic v, input logic s, input logic e);
        @(posedge clk); #1;
        bit_stb = 1'b1; d = b; bit_valid = v; sync = s; se0 = e;
        @(posedge clk); #1;
        bit_stb = 1'b0; d = 1'b0; bit_valid = 1'b0; sync = 1'b0; se0 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        strobe(b, 1'b1, 1'b0, 1'b0);
        ones = b ? ones + 1 : 0;
        if (stuff_en && ones == 6) begin
            strobe(1'b0, 1'b0, 1'b0, 1'b0);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic start_pkt();
        ones = 0;
        strobe(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic end_pkt();
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        strobe(1'b0, 1'b0, 1'b0, 1'b1);
        strobe(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_crc_rst_n", {7'd0, crc_rst_n}, 8'h00);
        chk("rst_rx_active", {7'd0, rx_active}, 8'h00);
        chk("rst_outputs", {pid_valid, data_stb, pkt_end, pkt_ok, pkt_err, 3'd0}, 8'h00);
        chk("rst_rx_pid", {4'd0, rx_pid}, 8'h00);
        chk("rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // ACK
        push(E_PID, 8'h02); push(E_END, 8'h02);
        start_pkt();
        @(negedge clk);
        chk("ack_rx_active", {7'd0, rx_active}, 8'h01);
        chk("ack_crc_armed", {7'd0, crc_rst_n}, 8'h01);
        send_byte(8'hD2);
        end_pkt();
        @(negedge clk);
        chk("ack_idle_after_j", {7'd0, rx_active}, 8'h00);
        chk("ack_crc_preset", {7'd0, crc_rst_n}, 8'h00);

        // IN token, good CRC5
        push(E_PID, 8'h09); push(E_DATA, 8'h00); push(E_DATA, 8'h10); push(E_END, 8'h02);
        start_pkt(); send_byte(8'h69); send_byte(8'h00); send_byte(8'h10); end_pkt();

        // IN token, one body bit flipped
        push(E_PID, 8'h09); push(E_DATA, 8'h01); push(E_DATA, 8'h10); push(E_END, 8'h01);
        start_pkt(); send_byte(8'h69); send_byte(8'h01); send_byte(8'h10); end_pkt();

        // DATA0 zero-length
        push(E_PID, 8'h03); push(E_DATA, 8'h00); push(E_DATA, 8'h00); push(E_END, 8'h02);
        start_pkt(); send_byte(8'hC3); send_byte(8'h00); send_byte(8'h00); end_pkt();

        // DATA0 truncated to 7 bits of the last byte
        push(E_PID, 8'h03); push(E_DATA, 8'h00); push(E_END, 8'h01);
        start_pkt(); send_byte(8'hC3); send_byte(8'h00);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        end_pkt();

        // Bad PID check: nothing until SE0, then error
        push(E_END, 8'h01);
        start_pkt(); send_byte(8'hD3); send_byte(8'h00);
        @(negedge clk);
        chk("badpid_active", {7'd0, rx_active}, 8'h01);
        end_pkt();
        @(negedge clk);
        chk("badpid_idle", {7'd0, rx_active}, 8'h00);

        // Token with six 1s, without and with a stuff strobe
        for (int s = 0; s < 2; s++) begin
            stuff_en = (s == 1);
            push(E_PID, 8'h09); push(E_DATA, 8'h3F); push(E_DATA, 8'h70); push(E_END, 8'h02);
            start_pkt(); send_byte(8'h69); send_byte(8'h3F); send_byte(8'h70); end_pkt();
        end
        stuff_en = 1'b0;

        // Handshake with an unexpected byte
        push(E_PID, 8'h02); push(E_END, 8'h01);
        start_pkt(); send_byte(8'hD2); send_byte(8'h00); end_pkt();

        // Token with a third byte
        push(E_PID, 8'h09); push(E_DATA, 8'h00); push(E_DATA, 8'h10); push(E_END, 8'h01);
        start_pkt(); send_byte(8'h69); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        end_pkt();

        // Bus reset mid-DATA1 body
        push(E_PID, 8'h0B); push(E_DATA, 8'h55);
        start_pkt(); send_byte(8'h4B); send_byte(8'h55);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #1; usb_rst = 1'b1;
        @(posedge clk); #1; usb_rst = 1'b0;
        @(negedge clk);
        chk("usbrst_rx_active", {7'd0, rx_active}, 8'h00);
        chk("usbrst_crc_rst_n", {7'd0, crc_rst_n}, 8'h00);
        chk("usbrst_verdict_held", {6'd0, pkt_ok, pkt_err}, 8'h01);
        repeat (8) @(posedge clk);
        push(E_PID, 8'h02); push(E_END, 8'h02);
        start_pkt(); send_byte(8'hD2); end_pkt();

        // EOP in the middle of the PID
        push(E_END, 8'h01);
        start_pkt();
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        end_pkt();

        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events got %0d still queued, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
